// File: rtl/ram_ctl_defs.v
// Shared definitions for ram_ctl: FSM state encodings and the default wait-state count.
// Guarded so it may be both listed as a source and pulled in by an include directive.
`ifndef RAM_CTL_DEFS_V
`define RAM_CTL_DEFS_V

package ram_ctl_defs_pkg;

    localparam int RAM_CTL_WAIT_STATES_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_HOLD  = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

`endif

// File: rtl/ram_ctl.sv
// ram_ctl: bus-to-asynchronous-SRAM controller with programmable wait states and a
// 4-phase ready handshake; one access in flight at a time.
`include "ram_ctl_defs.v"

module ram_ctl
    import ram_ctl_defs_pkg::*;
#(
    parameter int WAIT_STATES = RAM_CTL_WAIT_STATES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] ram_addr,
    input  logic [15:0] ram_data_out,
    output logic [15:0] ram_data_in,
    input  logic        ram_rd,
    input  logic        ram_wr,
    input  logic        ram_byte_op,
    output logic        ram_ready,
    output logic [17:0] sram_a,
    inout  wire  [15:0] sram_io,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        byte_q;
    logic        lane_q;
    logic        ready_q, ready_d;
    logic        armed_q;
    logic        latch;
    logic        capture;
    logic        drive;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^ram_addr[21:19];

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        ready_d = 1'b0;
        capture = 1'b0;
        case (state_q)
            // armed_q keeps the first edge after reset release from sampling a request
            IDLE: begin
                if (armed_q) begin
                    if (ram_wr) begin
                        state_d = WR_SETUP;
                    end else if (ram_rd) begin
                        state_d = RD;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
            RD: begin
                if (wait_q == 4'd0) begin
                    state_d = DONE;
                    capture = 1'b1;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                wait_d  = WAIT_LOAD;
            end
            WR_PULSE: begin
                if (wait_q == 4'd0) begin
                    state_d = WR_HOLD;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            WR_HOLD: begin
                state_d = DONE;
            end
            DONE: begin
                // Leave only once ready has been seen high and the request has dropped
                if (ready_q && !ram_rd && !ram_wr) begin
                    state_d = IDLE;
                end else begin
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign latch = (state_q == IDLE) && (state_d != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            addr_q  <= 18'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
            byte_q  <= 1'b0;
            lane_q  <= 1'b0;
            ready_q <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            ready_q <= ready_d;
            armed_q <= 1'b1;
            if (latch) begin
                addr_q  <= ram_addr[18:1];
                wdata_q <= ram_byte_op ? {ram_data_out[7:0], ram_data_out[7:0]} : ram_data_out;
                byte_q  <= ram_byte_op;
                lane_q  <= ram_addr[0];
            end
            if (capture) begin
                rdata_q <= sram_io;
            end
        end
    end

    // Strobes decode straight from state_q so an asynchronous reset clears them at once
    always_comb begin
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_ub_n = 1'b1;
        sram_lb_n = 1'b1;
        drive     = 1'b0;
        case (state_q)
            RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
            end
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                sram_ce_n = 1'b0;
                sram_we_n = (state_q != WR_PULSE);
                sram_ub_n = byte_q & ~lane_q;
                sram_lb_n = byte_q & lane_q;
                drive     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign sram_io     = drive ? wdata_q : 16'hzzzz;
    assign sram_a      = addr_q;
    assign ram_data_in = rdata_q;
    assign ram_ready   = ready_q;

endmodule

// File: tb/tb_ram_ctl.sv
// Testbench for ram_ctl: one instance with WAIT_STATES=2 and one with WAIT_STATES=0,
// each attached to a behavioural SRAM; table-driven accesses plus hand-written corner cases.
module tb_ram_ctl;

    localparam int WS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  rd_s, wr_s, bop_s, ready_s;
    logic [1:0]  ce_s, oe_s, we_s, ub_s, lb_s;
    logic [21:0] addr_s  [2];
    logic [15:0] wdat_s  [2];
    logic [15:0] rdata_s [2];
    logic [17:0] a_s     [2];
    wire  [15:0] io0, io1;

    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];

    ram_ctl #(.WAIT_STATES(WS)) u_dut (
        .clk(clk), .reset(reset),
        .ram_addr(addr_s[0]), .ram_data_out(wdat_s[0]), .ram_data_in(rdata_s[0]),
        .ram_rd(rd_s[0]), .ram_wr(wr_s[0]), .ram_byte_op(bop_s[0]), .ram_ready(ready_s[0]),
        .sram_a(a_s[0]), .sram_io(io0),
        .sram_ce_n(ce_s[0]), .sram_oe_n(oe_s[0]), .sram_we_n(we_s[0]),
        .sram_ub_n(ub_s[0]), .sram_lb_n(lb_s[0])
    );

    ram_ctl #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .ram_addr(addr_s[1]), .ram_data_out(wdat_s[1]), .ram_data_in(rdata_s[1]),
        .ram_rd(rd_s[1]), .ram_wr(wr_s[1]), .ram_byte_op(bop_s[1]), .ram_ready(ready_s[1]),
        .sram_a(a_s[1]), .sram_io(io1),
        .sram_ce_n(ce_s[1]), .sram_oe_n(oe_s[1]), .sram_we_n(we_s[1]),
        .sram_ub_n(ub_s[1]), .sram_lb_n(lb_s[1])
    );

    // Behavioural SRAMs: drive the bus while read-enabled, write enabled lanes each edge of a we pulse
    assign io0 = (!ce_s[0] && !oe_s[0] && we_s[0]) ? mem0[a_s[0]] : 16'hzzzz;
    assign io1 = (!ce_s[1] && !oe_s[1] && we_s[1]) ? mem1[a_s[1]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!ce_s[0] && !we_s[0]) begin
            if (!lb_s[0]) mem0[a_s[0]][7:0]  <= io0[7:0];
            if (!ub_s[0]) mem0[a_s[0]][15:8] <= io0[15:8];
        end
        if (!ce_s[1] && !we_s[1]) begin
            if (!lb_s[1]) mem1[a_s[1]][7:0]  <= io1[7:0];
            if (!ub_s[1]) mem1[a_s[1]][15:8] <= io1[15:8];
        end
    end

    int ub_cnt [2];
    int lb_cnt [2];
    int oe_cnt [2];
    int rl_cnt [2];
    int starts [2];
    logic [1:0] ce_prev = 2'b11;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!ce_s[k] && !we_s[k]) begin
                if (!ub_s[k]) ub_cnt[k] <= ub_cnt[k] + 1;
                if (!lb_s[k]) lb_cnt[k] <= lb_cnt[k] + 1;
            end
            if (!ce_s[k] && !oe_s[k]) begin
                oe_cnt[k] <= oe_cnt[k] + 1;
                if (!ub_s[k] && !lb_s[k]) rl_cnt[k] <= rl_cnt[k] + 1;
            end
            if (ce_prev[k] && !ce_s[k]) starts[k] <= starts[k] + 1;
            ce_prev[k] <= ce_s[k];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request and count edges until ready; lat = edges after the first edge (-1 on timeout)
    task automatic do_access(input int k, input logic rd, input logic wr, input logic bop,
                             input logic [21:0] a, input logic [15:0] d, input logic scr,
                             output int lat);
        addr_s[k] = a;
        wdat_s[k] = d;
        bop_s[k]  = bop;
        rd_s[k]   = rd;
        wr_s[k]   = wr;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (ready_s[k]) begin
                lat = n - 1;
                break;
            end
            if (scr && n == 1) begin
                addr_s[k] = a ^ 22'h3FFFFF;
                wdat_s[k] = ~d;
                bop_s[k]  = ~bop;
            end
        end
    endtask

    task automatic release_req(input int k, input string name);
        rd_s[k] = 1'b0;
        wr_s[k] = 1'b0;
        @(posedge clk);
        #1;
        check(name, {31'd0, ready_s[k]}, 32'd0);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic        bop;
        logic [21:0] addr;
        logic [15:0] data;
        int          lat;
        logic [15:0] rdata;
        int          ub;
        int          lb;
        int          oe;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ub0, lb0, oe0, rl0, st0;
        int bad;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 22'o001000,  16'h0000, WS+2, 16'hA72E, 0,    0,    WS+1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 22'o001000,  16'h0000, WS+4, 16'hA72E, WS+1, WS+1, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 22'o001001,  16'hAB34, WS+4, 16'hA72E, WS+1, 0,    0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 22'o001000,  16'hCD12, WS+4, 16'hA72E, 0,    WS+1, 0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 22'o001000,  16'h0000, WS+2, 16'h3412, 0,    0,    WS+1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 22'o001001,  16'h0000, WS+2, 16'h3412, 0,    0,    WS+1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 22'h280800,  16'h5A5A, WS+4, 16'h3412, WS+1, WS+1, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 22'h000800,  16'h0000, WS+2, 16'h5A5A, 0,    0,    WS+1};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 22'o002000,  16'h0F0F, WS+4, 16'h5A5A, WS+1, WS+1, 0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 22'o002000,  16'h0000, WS+2, 16'h0F0F, 0,    0,    WS+1};

        reset = 1'b0;
        rd_s = 2'b00; wr_s = 2'b00; bop_s = 2'b00;
        for (int k = 0; k < 2; k++) begin
            addr_s[k] = 22'd0;
            wdat_s[k] = 16'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_ready[%0d]", k), {31'd0, ready_s[k]}, 32'd0);
            check($sformatf("reset_rdata[%0d]", k), {16'd0, rdata_s[k]}, 32'd0);
            check($sformatf("reset_sram_a[%0d]", k), {14'd0, a_s[k]}, 32'd0);
            check($sformatf("reset_strobes[%0d]", k),
                  {27'd0, ce_s[k], oe_s[k], we_s[k], ub_s[k], lb_s[k]}, 32'h1F);
        end

        // Request presented together with reset release: the first edge must not sample it
        reset = 1'b1;
        do_access(0, 1'b0, 1'b1, 1'b0, 22'o001000, 16'o123456, 1'b0, lat);
        check("post_reset_latency_ge", {31'd0, (lat >= WS + 5)}, 32'd1);
        check("post_reset_rdata", {16'd0, rdata_s[0]}, 32'd0);
        release_req(0, "post_reset_release");
        $display("txn post_reset wr addr=%o lat=%0d", 22'o001000, lat);

        for (int i = 0; i < 10; i++) begin
            ub0 = ub_cnt[0]; lb0 = lb_cnt[0]; oe0 = oe_cnt[0]; rl0 = rl_cnt[0];
            do_access(0, vecs[i].rd, vecs[i].wr, vecs[i].bop, vecs[i].addr, vecs[i].data, 1'b1, lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_rdata", i), {16'd0, rdata_s[0]}, {16'd0, vecs[i].rdata});
            check($sformatf("v%0d_ub_pulses", i), ub_cnt[0] - ub0, vecs[i].ub);
            check($sformatf("v%0d_lb_pulses", i), lb_cnt[0] - lb0, vecs[i].lb);
            check($sformatf("v%0d_oe_cycles", i), oe_cnt[0] - oe0, vecs[i].oe);
            check($sformatf("v%0d_read_lanes", i), rl_cnt[0] - rl0, vecs[i].oe);
            release_req(0, $sformatf("v%0d_release", i));
            $display("txn v%0d rd=%0b wr=%0b byte=%0b addr=%h data=%h lat=%0d rdata=%h",
                     i, vecs[i].rd, vecs[i].wr, vecs[i].bop, vecs[i].addr, vecs[i].data, lat, rdata_s[0]);
        end

        // Held read: one access only, ready stays high until the request drops
        st0 = starts[0];
        do_access(0, 1'b1, 1'b0, 1'b0, 22'o001000, 16'h0000, 1'b0, lat);
        check("held_latency", lat, WS + 2);
        check("held_rdata", {16'd0, rdata_s[0]}, 32'h3412);
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (!ready_s[0]) bad++;
        end
        check("held_ready_low_cycles", bad, 0);
        check("held_starts", starts[0] - st0, 1);
        release_req(0, "held_release");
        repeat (3) @(posedge clk);
        #1;
        check("held_no_retrigger", starts[0] - st0, 1);
        $display("txn held rd addr=%o lat=%0d rdata=%h", 22'o001000, lat, rdata_s[0]);

        // Reset asserted in the middle of the write pulse
        addr_s[0] = 22'o003000; wdat_s[0] = 16'h1111; bop_s[0] = 1'b0; wr_s[0] = 1'b1;
        bad = 1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (!we_s[0]) begin
                bad = 0;
                break;
            end
        end
        check("midwr_pulse_seen", bad, 0);
        #2;
        reset = 1'b0;
        #1;
        check("midwr_we_n", {31'd0, we_s[0]}, 32'd1);
        check("midwr_ce_n", {31'd0, ce_s[0]}, 32'd1);
        check("midwr_lanes", {30'd0, ub_s[0], lb_s[0]}, 32'd3);
        check("midwr_ready", {31'd0, ready_s[0]}, 32'd0);
        check("midwr_rdata", {16'd0, rdata_s[0]}, 32'd0);
        check("midwr_sram_a", {14'd0, a_s[0]}, 32'd0);
        wr_s[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        $display("txn reset_mid_write addr=%o we_n=%0b", 22'o003000, we_s[0]);
        repeat (2) @(posedge clk);
        #1;

        // Zero wait states: write then read back
        ub0 = ub_cnt[1]; lb0 = lb_cnt[1];
        do_access(1, 1'b0, 1'b1, 1'b0, 22'o000024, 16'h4321, 1'b1, lat);
        check("ws0_wr_latency", lat, 4);
        check("ws0_ub_pulses", ub_cnt[1] - ub0, 1);
        check("ws0_lb_pulses", lb_cnt[1] - lb0, 1);
        release_req(1, "ws0_wr_release");
        $display("txn ws0 wr addr=%o data=4321 lat=%0d", 22'o000024, lat);
        oe0 = oe_cnt[1];
        do_access(1, 1'b1, 1'b0, 1'b0, 22'o000024, 16'h0000, 1'b1, lat);
        check("ws0_rd_latency", lat, 2);
        check("ws0_oe_cycles", oe_cnt[1] - oe0, 1);
        check("ws0_rdata", {16'd0, rdata_s[1]}, 32'h4321);
        release_req(1, "ws0_rd_release");
        $display("txn ws0 rd addr=%o lat=%0d rdata=%h", 22'o000024, lat, rdata_s[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
